// File: rtl/gpio_in_conditioner_pkg.sv
// Shared definitions for the GPIO input conditioner: register map, field
// positions and the bus address decoder.
package gpio_in_conditioner_pkg;

  localparam int          NUM_PINS   = 8;
  localparam logic [31:0] STATUS_OFF = 32'h0;
  localparam logic [31:0] ENABLE_OFF = 32'h4;
  localparam int          RISE_LSB   = 0;
  localparam int          FALL_LSB   = 8;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_STATUS,
    REG_ENABLE
  } reg_sel_e;

  function automatic reg_sel_e decode_reg(input logic        valid,
                                          input logic [31:0] addr,
                                          input logic [31:0] base);
    if (!valid)                    return REG_NONE;
    if (addr == base + STATUS_OFF) return REG_STATUS;
    if (addr == base + ENABLE_OFF) return REG_ENABLE;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/gpio_in_conditioner_debounce_bit.sv
// One pin: 2-flop synchroniser, consecutive-difference counter and clean flop.
// rise_o/fall_o flag the clean transition that happens at the next posedge.
module gpio_debounce_bit
  import gpio_in_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic resetn,
  input  logic pin_raw_i,
  output logic pin_clean_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = '0;
    if (s2_q != clean_q) begin
      if (cnt_q == CNT_MAX) clean_d = s2_q;
      else                  cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= pin_raw_i;
      s2_q    <= s1_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pin_clean_o = clean_q;
  assign rise_o      = clean_d & ~clean_q;
  assign fall_o      = ~clean_d & clean_q;

endmodule

// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: per-pin debounce plus W1C edge status, interrupt
// enable mask and registered interrupt on the single-cycle memory bus.
module gpio_in_conditioner
  import gpio_in_conditioner_pkg::*;
#(
  parameter logic [31:0] ADDR            = 32'hffff_fff0,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          CNT_W           = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        edge_ready,
  output logic        edge_sel,
  output logic [31:0] edge_rdata,
  input  logic [7:0]  pin_raw,
  output logic [7:0]  pin_clean,
  output logic        edge_irq
);

  logic [NUM_PINS-1:0] rise, fall;
  logic [15:0]         status_q, status_d;
  logic [15:0]         enable_q, enable_d;
  logic [15:0]         hw_set, w1c;
  logic                irq_q;
  logic                wr_en;
  reg_sel_e            sel;
  logic                unused_wdata_hi;

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    gpio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk        (clk),
      .resetn     (resetn),
      .pin_raw_i  (pin_raw[i]),
      .pin_clean_o(pin_clean[i]),
      .rise_o     (rise[i]),
      .fall_o     (fall[i])
    );
  end

  assign sel             = decode_reg(mem_valid, mem_addr, ADDR);
  assign edge_sel        = (sel != REG_NONE);
  assign edge_ready      = 1'b1;
  assign wr_en           = edge_sel && (mem_wstrb != 4'b0000);
  assign unused_wdata_hi = ^mem_wdata[31:16];

  always_comb begin
    w1c      = '0;
    enable_d = enable_q;
    hw_set   = '0;
    hw_set[RISE_LSB +: NUM_PINS] = rise;
    hw_set[FALL_LSB +: NUM_PINS] = fall;
    if (wr_en) begin
      case (sel)
        REG_STATUS: begin
          if (mem_wstrb[0]) w1c[7:0]  = mem_wdata[7:0];
          if (mem_wstrb[1]) w1c[15:8] = mem_wdata[15:8];
        end
        REG_ENABLE: begin
          if (mem_wstrb[0]) enable_d[7:0]  = mem_wdata[7:0];
          if (mem_wstrb[1]) enable_d[15:8] = mem_wdata[15:8];
        end
        default: ;
      endcase
    end
    // A hardware set lands after the clear, so it wins over a same-cycle W1C.
    status_d = (status_q & ~w1c) | hw_set;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      status_q <= '0;
      enable_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      enable_q <= enable_d;
      irq_q    <= |(status_d & enable_d);
    end
  end

  assign edge_irq = irq_q;

  always_comb begin
    edge_rdata = '0;
    case (sel)
      REG_STATUS: edge_rdata = {16'h0000, status_q};
      REG_ENABLE: edge_rdata = {16'h0000, enable_q};
      default:    edge_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized pins/bus traffic compared every cycle against a behavioural model.
module tb_gpio_in_conditioner;

  localparam logic [31:0] BASE = 32'hffff_fff0;
  localparam int          D    = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        edge_ready, edge_sel, edge_irq;
  logic [31:0] edge_rdata;
  logic [7:0]  pin_raw, pin_clean;

  int n_checks = 0;
  int n_fail   = 0;

  gpio_in_conditioner #(
    .ADDR(BASE), .DEBOUNCE_CYCLES(D), .CNT_W(5)
  ) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .edge_ready(edge_ready), .edge_sel(edge_sel), .edge_rdata(edge_rdata),
    .pin_raw(pin_raw), .pin_clean(pin_clean), .edge_irq(edge_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the clean value flips once the last D synchronised
  // samples since reset all disagree with it.
  logic [7:0]  m_s1, m_s2, m_clean, m_new_clean;
  logic [15:0] m_status, m_enable, m_set, m_clr;
  logic        m_irq;
  logic [7:0]  hist[$];
  bit          model_valid = 0;
  bit          all_differ;

  always @(posedge clk) begin
    if (!resetn) begin
      m_s1 = 0; m_s2 = 0; m_clean = 0; m_status = 0; m_enable = 0; m_irq = 0;
      hist.delete();
      model_valid = 1;
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > D) hist.delete(0);
      m_new_clean = m_clean;
      m_set = 0;
      if (hist.size() == D) begin
        for (int i = 0; i < 8; i++) begin
          all_differ = 1;
          for (int j = 0; j < D; j++)
            if (hist[j][i] == m_clean[i]) all_differ = 0;
          if (all_differ) begin
            m_new_clean[i] = ~m_clean[i];
            if (m_new_clean[i]) m_set[i] = 1'b1;
            else                m_set[i+8] = 1'b1;
          end
        end
      end
      m_clr = 0;
      if (mem_valid && mem_wstrb != 0 && mem_addr == BASE) begin
        if (mem_wstrb[0]) m_clr[7:0]  = mem_wdata[7:0];
        if (mem_wstrb[1]) m_clr[15:8] = mem_wdata[15:8];
      end
      if (mem_valid && mem_wstrb != 0 && mem_addr == BASE + 32'd4) begin
        if (mem_wstrb[0]) m_enable[7:0]  = mem_wdata[7:0];
        if (mem_wstrb[1]) m_enable[15:8] = mem_wdata[15:8];
      end
      m_status = (m_status & ~m_clr) | m_set;
      m_irq    = |(m_status & m_enable);
      m_clean  = m_new_clean;
      m_s2     = m_s1;
      m_s1     = pin_raw;
    end
  end

  function automatic logic [31:0] model_rdata();
    if (!mem_valid)                 return 32'h0;
    if (mem_addr == BASE)           return {16'h0, m_status};
    if (mem_addr == BASE + 32'd4)   return {16'h0, m_enable};
    return 32'h0;
  endfunction

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_pin_clean", 32'(pin_clean), 32'(m_clean));
      check("model_edge_irq", 32'(edge_irq), 32'(m_irq));
      check("model_edge_sel", 32'(edge_sel),
            32'(mem_valid && (mem_addr == BASE || mem_addr == BASE + 32'd4)));
      check("model_edge_rdata", edge_rdata, model_rdata());
      check("model_edge_ready", 32'(edge_ready), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_valid = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    tick();
    mem_valid = 0; mem_wstrb = 0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp,
                            input logic exp_sel);
    mem_valid = 1; mem_addr = a; mem_wstrb = 0;
    #1;
    check({name, "_rdata"}, edge_rdata, exp);
    check({name, "_sel"}, 32'(edge_sel), 32'(exp_sel));
    mem_valid = 0;
  endtask

  initial begin
    resetn = 0; mem_valid = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0; pin_raw = 0;
    repeat (2) tick();
    check("reset_clean", 32'(pin_clean), 32'h0);
    check("reset_irq", 32'(edge_irq), 32'h0);
    resetn = 1;
    repeat (2) tick();
    read_check("reset_status", BASE, 32'h0, 1'b1);

    // Single rise on pin 0: clean follows 1+D posedges after the first stable sample.
    pin_raw = 8'h01;
    repeat (5) tick();
    check("rise0_early", 32'(pin_clean), 32'h00);
    tick();
    check("rise0_clean", 32'(pin_clean), 32'h01);
    read_check("rise0_status", BASE, 32'h0001, 1'b1);
    check("rise0_irq_masked", 32'(edge_irq), 32'h0);

    // Glitch of D-1 cycles on pin 3 is rejected.
    pin_raw = 8'h09;
    repeat (3) tick();
    pin_raw = 8'h01;
    repeat (8) tick();
    check("glitch_clean", 32'(pin_clean), 32'h01);
    read_check("glitch_status", BASE, 32'h0001, 1'b1);

    // Enabling with a pending flag raises the interrupt.
    bus_write(BASE + 32'd4, 32'h0000_ffff, 4'b0011);
    check("enable_irq", 32'(edge_irq), 32'h1);
    read_check("enable_rd", BASE + 32'd4, 32'h0000_ffff, 1'b1);
    pin_raw = 8'hff;
    repeat (6) tick();
    check("all_rise_clean", 32'(pin_clean), 32'hff);
    read_check("all_rise_status", BASE, 32'h00ff, 1'b1);
    pin_raw = 8'h00;
    repeat (6) tick();
    check("all_fall_clean", 32'(pin_clean), 32'h00);
    read_check("all_fall_status", BASE, 32'hffff, 1'b1);

    // W1C of bits 0 and 8, then the same W1C colliding with a new rise on bit 0.
    bus_write(BASE, 32'h0000_0101, 4'b0011);
    read_check("w1c_status", BASE, 32'hfefe, 1'b1);
    pin_raw = 8'h01;
    repeat (5) tick();
    bus_write(BASE, 32'h0000_0101, 4'b0011);
    check("collide_clean", 32'(pin_clean), 32'h01);
    read_check("collide_status", BASE, 32'hfeff, 1'b1);

    // Reset mid-count discards progress.
    pin_raw = 8'h80;
    repeat (3) tick();
    resetn = 0;
    tick();
    check("midrst_clean", 32'(pin_clean), 32'h0);
    check("midrst_irq", 32'(edge_irq), 32'h0);
    read_check("midrst_status", BASE, 32'h0, 1'b1);
    read_check("midrst_enable", BASE + 32'd4, 32'h0, 1'b1);
    resetn = 1;
    repeat (5) tick();
    check("postrst_early", 32'(pin_clean), 32'h00);
    tick();
    check("postrst_clean", 32'(pin_clean), 32'h80);

    // Unmapped addresses: no select, zero data, no state change.
    read_check("unmapped_plus8", BASE + 32'd8, 32'h0, 1'b0);
    read_check("unmapped_low", 32'h0000_1000, 32'h0, 1'b0);
    bus_write(BASE + 32'd8, 32'hffff_ffff, 4'b1111);
    read_check("unmapped_nochange", BASE, 32'h0080, 1'b1);

    // Randomized pins and bus traffic, checked by the per-cycle compare.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 4) == 0) pin_raw = pin_raw ^ 8'($urandom & $urandom);
      mem_valid = 0; mem_wstrb = 0;
      mem_addr = $urandom; mem_wdata = $urandom;
      case ($urandom_range(0, 11))
        0, 1: begin mem_valid = 1; mem_addr = BASE; mem_wstrb = 4'($urandom); end
        2:    begin mem_valid = 1; mem_addr = BASE + 32'd4; mem_wstrb = 4'($urandom); end
        3: begin
          mem_valid = 1;
          case ($urandom_range(0, 3))
            0: mem_addr = BASE;
            1: mem_addr = BASE + 32'd4;
            2: mem_addr = BASE + 32'd8;
            default: ;
          endcase
        end
        4: begin
          mem_valid = 1; mem_wstrb = 4'($urandom);
          if ($urandom_range(0, 1) == 0) mem_addr = BASE + 32'd8;
        end
        default: ;
      endcase
      resetn = ($urandom_range(0, 499) != 0);
      tick();
    end

    resetn = 1; mem_valid = 0; mem_wstrb = 0;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
